// File: rtl/axilite_arb2.sv
`default_nettype none
// axilite_arb2 -- two-requester AXI4-Lite arbiter onto one master port; round-robin per direction.
// Rev 1.0 -- one outstanding write and one outstanding read, every output registered.
module axilite_arb2 #(
  parameter int AW = 17
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      s_axi_awvalid,
  output logic [1:0]      s_axi_awready,
  input  logic [2*AW-1:0] s_axi_awaddr,
  input  logic [1:0]      s_axi_wvalid,
  output logic [1:0]      s_axi_wready,
  input  logic [63:0]     s_axi_wdata,
  input  logic [7:0]      s_axi_wstrb,
  output logic [1:0]      s_axi_bvalid,
  input  logic [1:0]      s_axi_bready,
  output logic [1:0]      s_axi_bresp,
  input  logic [1:0]      s_axi_arvalid,
  output logic [1:0]      s_axi_arready,
  input  logic [2*AW-1:0] s_axi_araddr,
  output logic [1:0]      s_axi_rvalid,
  input  logic [1:0]      s_axi_rready,
  output logic [31:0]     s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [AW-1:0]   m_axi_awaddr,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  output logic [31:0]     m_axi_wdata,
  output logic [3:0]      m_axi_wstrb,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  input  logic [1:0]      m_axi_bresp,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  output logic [AW-1:0]   m_axi_araddr,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready,
  input  logic [31:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  output logic            wr_grant,
  output logic            rd_grant
);

  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_ADDR  = 3'd1;
  localparam logic [2:0] W_DATA  = 3'd2;
  localparam logic [2:0] W_MRESP = 3'd3;
  localparam logic [2:0] W_SRESP = 3'd4;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ADDR  = 2'd1;
  localparam logic [1:0] R_MDATA = 2'd2;
  localparam logic [1:0] R_SDATA = 2'd3;

  logic [2:0]    wr_state;
  logic [1:0]    rd_state;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          wr_sel;
  logic          rd_sel;
  logic [AW-1:0] awaddr_sel;
  logic [AW-1:0] araddr_sel;
  logic [31:0]   wdata_sel;
  logic [3:0]    wstrb_sel;

  // Pointer holds the last winner; on contention the other port wins.
  assign wr_sel     = (&s_axi_awvalid) ? ~wr_ptr : s_axi_awvalid[1];
  assign rd_sel     = (&s_axi_arvalid) ? ~rd_ptr : s_axi_arvalid[1];
  assign awaddr_sel = wr_sel ? s_axi_awaddr[2*AW-1:AW] : s_axi_awaddr[AW-1:0];
  assign araddr_sel = rd_sel ? s_axi_araddr[2*AW-1:AW] : s_axi_araddr[AW-1:0];
  assign wdata_sel  = wr_grant ? s_axi_wdata[63:32] : s_axi_wdata[31:0];
  assign wstrb_sel  = wr_grant ? s_axi_wstrb[7:4] : s_axi_wstrb[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state      <= W_IDLE;
      wr_ptr        <= 1'b1;
      wr_grant      <= 1'b0;
      s_axi_awready <= 2'b00;
      s_axi_wready  <= 2'b00;
      s_axi_bvalid  <= 2'b00;
      s_axi_bresp   <= 2'b00;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= 32'd0;
      m_axi_wstrb   <= 4'd0;
      m_axi_bready  <= 1'b0;
    end else begin
      s_axi_awready <= 2'b00;
      s_axi_wready  <= 2'b00;
      case (wr_state)
        W_IDLE: begin
          if (|s_axi_awvalid) begin
            wr_grant      <= wr_sel;
            m_axi_awaddr  <= awaddr_sel;
            m_axi_awvalid <= 1'b1;
            wr_state      <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (m_axi_awvalid && m_axi_awready) begin
            m_axi_awvalid           <= 1'b0;
            s_axi_awready[wr_grant] <= 1'b1;
            wr_state                <= W_DATA;
          end
        end
        W_DATA: begin
          if (!m_axi_wvalid && s_axi_wvalid[wr_grant]) begin
            m_axi_wdata  <= wdata_sel;
            m_axi_wstrb  <= wstrb_sel;
            m_axi_wvalid <= 1'b1;
          end
          // Requester's wready only pulses once the master has taken the beat.
          if (m_axi_wvalid && m_axi_wready) begin
            m_axi_wvalid           <= 1'b0;
            s_axi_wready[wr_grant] <= 1'b1;
            m_axi_bready           <= 1'b1;
            wr_state               <= W_MRESP;
          end
        end
        W_MRESP: begin
          if (m_axi_bvalid) begin
            s_axi_bresp            <= m_axi_bresp;
            m_axi_bready           <= 1'b0;
            s_axi_bvalid[wr_grant] <= 1'b1;
            wr_state               <= W_SRESP;
          end
        end
        W_SRESP: begin
          if (s_axi_bready[wr_grant]) begin
            s_axi_bvalid <= 2'b00;
            wr_ptr       <= wr_grant;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state      <= R_IDLE;
      rd_ptr        <= 1'b1;
      rd_grant      <= 1'b0;
      s_axi_arready <= 2'b00;
      s_axi_rvalid  <= 2'b00;
      s_axi_rdata   <= 32'd0;
      s_axi_rresp   <= 2'b00;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      s_axi_arready <= 2'b00;
      case (rd_state)
        R_IDLE: begin
          if (|s_axi_arvalid) begin
            rd_grant      <= rd_sel;
            m_axi_araddr  <= araddr_sel;
            m_axi_arvalid <= 1'b1;
            rd_state      <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid           <= 1'b0;
            s_axi_arready[rd_grant] <= 1'b1;
            m_axi_rready            <= 1'b1;
            rd_state                <= R_MDATA;
          end
        end
        R_MDATA: begin
          if (m_axi_rvalid) begin
            s_axi_rdata            <= m_axi_rdata;
            s_axi_rresp            <= m_axi_rresp;
            m_axi_rready           <= 1'b0;
            s_axi_rvalid[rd_grant] <= 1'b1;
            rd_state               <= R_SDATA;
          end
        end
        R_SDATA: begin
          if (s_axi_rready[rd_grant]) begin
            s_axi_rvalid <= 2'b00;
            rd_ptr       <= rd_grant;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axilite_arb2.sv
`default_nettype none
// tb_axilite_arb2 -- directed bench: two requester drivers, a stallable slave model, handshake monitor.
// Rev 1.0
module tb_axilite_arb2;
  localparam int AW  = 17;
  localparam int LIM = 300;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [1:0]      s_axi_bvalid, s_axi_bready, s_axi_bresp;
  logic [1:0]      s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready, s_axi_rresp;
  logic [2*AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [63:0]     s_axi_wdata;
  logic [7:0]      s_axi_wstrb;
  logic [31:0]     s_axi_rdata;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic            m_axi_rvalid, m_axi_rready;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [31:0]     m_axi_wdata, m_axi_rdata;
  logic [3:0]      m_axi_wstrb;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            wr_grant, rd_grant;

  axilite_arb2 #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .wr_grant(wr_grant), .rd_grant(rd_grant)
  );

  always #5 clk = ~clk;

  int passed = 0, failed = 0, total = 0, tmo = 0;
  int aw_stall = 0, w_stall = 0, b_stall = 0, ar_stall = 0, r_stall = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [AW-1:0] aw_log[$], ar_log[$], rq[$];
  logic [31:0]   w_log[$];
  logic [3:0]    s_log[$];
  int aw_hs[2] = '{0, 0}, w_hs[2] = '{0, 0}, b_hs[2] = '{0, 0};
  int viol = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s"}, 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                          s_axi_rvalid, s_axi_rresp, s_axi_rdata}), 64'd0);
    chk({tag, "_mw"}, 64'({m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
                           m_axi_bready}), 64'd0);
    chk({tag, "_mr"}, 64'({m_axi_arvalid, m_axi_araddr, m_axi_rready, wr_grant, rd_grant}), 64'd0);
  endtask

  // Handshake counters per port, and any ready/valid seen on the port not holding the grant.
  always @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        if (s_axi_awvalid[p] && s_axi_awready[p]) aw_hs[p] <= aw_hs[p] + 1;
        if (s_axi_wvalid[p] && s_axi_wready[p])   w_hs[p]  <= w_hs[p] + 1;
        if (s_axi_bvalid[p] && s_axi_bready[p])   b_hs[p]  <= b_hs[p] + 1;
      end
      if ((((s_axi_awready | s_axi_wready | s_axi_bvalid) & (wr_grant ? 2'b01 : 2'b10)) != 2'b00) ||
          (((s_axi_arready | s_axi_rvalid) & (rd_grant ? 2'b01 : 2'b10)) != 2'b00))
        viol <= viol + 1;
    end
  end

  initial begin : slave_w
    int awc, wc, bc, bpend;
    bit awf, wf, bf;
    awc = 0; wc = 0; bc = 0; bpend = 0; awf = 0; wf = 0; bf = 0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        awc = 0; wc = 0; bc = 0; bpend = 0; awf = 0; wf = 0; bf = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      end else begin
        if (awf) m_axi_awready = 1'b0;
        else if (m_axi_awvalid) begin
          if (awc < aw_stall) awc++;
          else begin awc = 0; m_axi_awready = 1'b1; aw_log.push_back(m_axi_awaddr); end
        end
        if (wf) m_axi_wready = 1'b0;
        else if (m_axi_wvalid) begin
          if (wc < w_stall) wc++;
          else begin
            wc = 0; m_axi_wready = 1'b1; bpend++;
            w_log.push_back(m_axi_wdata); s_log.push_back(m_axi_wstrb);
          end
        end
        if (bf) m_axi_bvalid = 1'b0;
        else if (!m_axi_bvalid && bpend > 0) begin
          if (bc < b_stall) bc++;
          else begin bc = 0; bpend--; m_axi_bvalid = 1'b1; m_axi_bresp = bresp_cfg; end
        end
        awf = m_axi_awvalid && m_axi_awready;
        wf  = m_axi_wvalid && m_axi_wready;
        bf  = m_axi_bvalid && m_axi_bready;
      end
    end
  end

  initial begin : slave_r
    int arc, rc;
    bit arf, rf;
    logic [AW-1:0] a;
    arc = 0; rc = 0; arf = 0; rf = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (reset) begin
        arc = 0; rc = 0; arf = 0; rf = 0; rq.delete();
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      end else begin
        if (arf) m_axi_arready = 1'b0;
        else if (m_axi_arvalid) begin
          if (arc < ar_stall) arc++;
          else begin
            arc = 0; m_axi_arready = 1'b1;
            ar_log.push_back(m_axi_araddr); rq.push_back(m_axi_araddr);
          end
        end
        if (rf) m_axi_rvalid = 1'b0;
        else if (!m_axi_rvalid && rq.size() > 0) begin
          if (rc < r_stall) rc++;
          else begin
            rc = 0; a = rq.pop_front();
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 32'hC0DE_0000 ^ {15'd0, a};
            m_axi_rresp  = rresp_cfg;
          end
        end
        arf = m_axi_arvalid && m_axi_arready;
        rf  = m_axi_rvalid && m_axi_rready;
      end
    end
  end

  task automatic wr_req(input int p, input logic [AW-1:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int bstall,
                        output logic [1:0] resp, output logic gnt, output int lat);
    int cnt;
    bit aw_go, w_go, aw_done, w_done;
    cnt = 0; aw_go = 0; w_go = 0; aw_done = 0; w_done = 0; lat = -1;
    @(negedge clk);
    s_axi_awaddr[p*AW +: AW] = addr;
    s_axi_wdata[p*32 +: 32]  = data;
    s_axi_wstrb[p*4 +: 4]    = strb;
    s_axi_awvalid[p] = 1'b1;
    s_axi_wvalid[p]  = 1'b1;
    while (!(aw_done && w_done) && cnt < LIM) begin
      @(negedge clk);
      cnt++;
      if (lat < 0 && m_axi_awvalid && (wr_grant == p[0])) lat = cnt;
      if (aw_go) begin s_axi_awvalid[p] = 1'b0; aw_go = 0; aw_done = 1; end
      if (w_go)  begin s_axi_wvalid[p]  = 1'b0; w_go = 0;  w_done = 1;  end
      if (s_axi_awvalid[p] && s_axi_awready[p]) aw_go = 1;
      if (s_axi_wvalid[p] && s_axi_wready[p])   w_go = 1;
    end
    while (!s_axi_bvalid[p] && cnt < LIM) begin @(negedge clk); cnt++; end
    if (cnt >= LIM) tmo++;
    repeat (bstall) @(negedge clk);
    resp = s_axi_bresp;
    gnt  = wr_grant;
    s_axi_bready[p] = 1'b1;
    @(negedge clk);
    s_axi_bready[p] = 1'b0;
  endtask

  task automatic rd_req(input int p, input logic [AW-1:0] addr, input int rstall,
                        output logic [31:0] data, output logic [1:0] resp, output logic gnt);
    int cnt;
    bit ar_go, ar_done;
    cnt = 0; ar_go = 0; ar_done = 0;
    @(negedge clk);
    s_axi_araddr[p*AW +: AW] = addr;
    s_axi_arvalid[p] = 1'b1;
    while (!ar_done && cnt < LIM) begin
      @(negedge clk);
      cnt++;
      if (ar_go) begin s_axi_arvalid[p] = 1'b0; ar_go = 0; ar_done = 1; end
      if (s_axi_arvalid[p] && s_axi_arready[p]) ar_go = 1;
    end
    while (!s_axi_rvalid[p] && cnt < LIM) begin @(negedge clk); cnt++; end
    if (cnt >= LIM) tmo++;
    repeat (rstall) @(negedge clk);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    gnt  = rd_grant;
    s_axi_rready[p] = 1'b1;
    @(negedge clk);
    s_axi_rready[p] = 1'b0;
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); s_log.delete(); ar_log.delete();
  endtask

  initial begin : stim
    logic [1:0]  r0, r1, rr;
    logic        g0, g1, rg;
    int          l0, l1, sa, sw, sb;
    logic [31:0] d;

    reset = 1'b1;
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_bready = '0; s_axi_arvalid = '0;
    s_axi_rready = '0; s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Single write from port 0.
    clear_logs();
    wr_req(0, 17'h10004, 32'hA5A5_0001, 4'hF, 0, r0, g0, l0);
    chk("t1_aw_latency", 64'(l0), 64'd1);
    chk("t1_aw_count", 64'(aw_log.size()), 64'd1);
    chk("t1_m_awaddr", 64'(aw_log[0]), 64'h10004);
    chk("t1_m_wdata", 64'(w_log[0]), 64'hA5A5_0001);
    chk("t1_m_wstrb", 64'(s_log[0]), 64'hF);
    chk("t1_bresp", 64'(r0), 64'd0);
    chk("t1_wr_grant", 64'(g0), 64'd0);

    // Port 1 read concurrent with port 0 write.
    clear_logs();
    fork
      wr_req(0, 17'h00040, 32'h1234_5678, 4'h3, 0, r0, g0, l0);
      rd_req(1, 17'h00020, 0, d, rr, rg);
    join
    chk("t3_rdata", 64'(d), 64'hC0DE_0020);
    chk("t3_rresp", 64'(rr), 64'd0);
    chk("t3_rd_grant", 64'(rg), 64'd1);
    chk("t3_m_araddr", 64'(ar_log[0]), 64'h00020);
    chk("t3_m_awaddr", 64'(aw_log[0]), 64'h00040);
    chk("t3_m_wdata", 64'(w_log[0]), 64'h1234_5678);
    chk("t3_m_wstrb", 64'(s_log[0]), 64'h3);
    chk("t3_wr_grant", 64'(g0), 64'd0);

    // Error responses forwarded unchanged.
    clear_logs();
    bresp_cfg = 2'b10; rresp_cfg = 2'b11;
    fork
      wr_req(1, 17'h1FFFC, 32'hDEAD_BEEF, 4'h8, 0, r1, g1, l1);
      rd_req(0, 17'h10010, 0, d, rr, rg);
    join
    chk("t4_bresp", 64'(r1), 64'h2);
    chk("t4_rresp", 64'(rr), 64'h3);
    chk("t4_rdata", 64'(d), 64'hC0DF_0010);
    chk("t4_wr_grant", 64'(g1), 64'd1);
    chk("t4_rd_grant", 64'(rg), 64'd0);
    chk("t4_m_awaddr", 64'(aw_log[0]), 64'h1FFFC);
    chk("t4_m_wstrb", 64'(s_log[0]), 64'h8);
    bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    // Slave stalls 10 cycles on every write channel; requester holds bready low 5 cycles.
    clear_logs();
    aw_stall = 10; w_stall = 10; b_stall = 10;
    sa = aw_hs[1]; sw = w_hs[1]; sb = b_hs[1];
    wr_req(1, 17'h0ABC8, 32'h0F0F_0F0F, 4'hF, 5, r1, g1, l1);
    @(negedge clk);
    chk("t5_aw_count", 64'(aw_log.size()), 64'd1);
    chk("t5_w_count", 64'(w_log.size()), 64'd1);
    chk("t5_m_awaddr", 64'(aw_log[0]), 64'h0ABC8);
    chk("t5_m_wdata", 64'(w_log[0]), 64'h0F0F_0F0F);
    chk("t5_s_aw_hs", 64'(aw_hs[1] - sa), 64'd1);
    chk("t5_s_w_hs", 64'(w_hs[1] - sw), 64'd1);
    chk("t5_s_b_hs", 64'(b_hs[1] - sb), 64'd1);
    chk("t5_bresp", 64'(r1), 64'd0);
    aw_stall = 0; w_stall = 0; b_stall = 0;

    // Reset while write sits in W_DATA and read sits in R_MDATA.
    w_stall = 50; r_stall = 50;
    @(negedge clk);
    s_axi_awaddr[AW +: AW] = 17'h00300; s_axi_wdata[63:32] = 32'h5555_AAAA;
    s_axi_wstrb[7:4] = 4'hF; s_axi_araddr[AW +: AW] = 17'h00304;
    s_axi_awvalid[1] = 1'b1; s_axi_wvalid[1] = 1'b1; s_axi_arvalid[1] = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_pre_wvalid", 64'(m_axi_wvalid), 64'd1);
    chk("t6_pre_wdata", 64'(m_axi_wdata), 64'h5555_AAAA);
    chk("t6_pre_rready", 64'(m_axi_rready), 64'd1);
    chk("t6_pre_rd_grant", 64'(rd_grant), 64'd1);
    reset = 1'b1;
    #1;
    chk_zero("t6_reset");
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_arvalid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    w_stall = 0; r_stall = 0;

    // Contended back-to-back writes: first grant to port 0, then strict alternation.
    clear_logs();
    fork
      begin
        for (int i = 0; i < 4; i++)
          wr_req(0, 17'h00100 + 17'(4 * i), 32'h0000_1000 + 32'(i), 4'hF, 0, r0, g0, l0);
      end
      begin
        for (int j = 0; j < 4; j++)
          wr_req(1, 17'h10200 + 17'(4 * j), 32'h0000_2000 + 32'(j), 4'hF, 0, r1, g1, l1);
      end
    join
    chk("t2_aw_count", 64'(aw_log.size()), 64'd8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_aw%0d_p0", i), 64'(aw_log[2*i]), 64'(17'h00100 + 17'(4 * i)));
      chk($sformatf("t2_aw%0d_p1", i), 64'(aw_log[2*i+1]), 64'(17'h10200 + 17'(4 * i)));
      chk($sformatf("t2_w%0d_p0", i), 64'(w_log[2*i]), 64'(32'h0000_1000 + 32'(i)));
      chk($sformatf("t2_w%0d_p1", i), 64'(w_log[2*i+1]), 64'(32'h0000_2000 + 32'(i)));
    end

    repeat (2) @(negedge clk);
    chk("ungranted_port_activity", 64'(viol), 64'd0);
    chk("timeouts", 64'(tmo), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
